// File: rtl/aes_key_expand_if.sv
// aes_key_expand_if: start/key request and round-key stream signals of the AES key expander
interface aes_key_expand_if;
   logic         start;
   logic [1:0]   key_len;
   logic [255:0] key_in;
   logic         busy;
   logic         err;
   logic         rk_valid;
   logic         rk_ready;
   logic [127:0] rk_data;
   logic [3:0]   rk_index;
   logic         rk_last;
   modport master (output start, key_len, key_in, rk_ready,
                   input busy, err, rk_valid, rk_data, rk_index, rk_last);
   modport slave (input start, key_len, key_in, rk_ready,
                  output busy, err, rk_valid, rk_data, rk_index, rk_last);
endinterface

// File: rtl/aes_key_expand.sv
// aes_key_expand: streams AES-128/192/256 round keys, one schedule word per unstalled cycle
module aes_key_expand #(
   parameter int MAX_KEY_BITS = 256
) (
   input logic clk,
   input logic rst,
   aes_key_expand_if.slave bus
);
   typedef enum logic [1:0] {IDLE, GEN, DRAIN} state_t;
   state_t       state;
   logic [1:0]   kl;
   logic [255:0] win;
   logic [31:0]  col [4];
   logic [2:0]   cc;
   logic [5:0]   gi;
   logic [2:0]   mc;
   logic [7:0]   rcon;
   logic [3:0]   nk_in, nk, nr;
   logic         legal, out_free, hs, gen;
   logic [31:0]  prev, old, sub_in, t, w;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // S-box as GF(2^8) inverse (a^254) followed by the affine map
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] p, r;
      p = a;
      r = 8'h01;
      for (int k = 1; k < 8; k++) begin
         p = gmul(p, p);
         r = gmul(r, p);
      end
      return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] x);
      return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
   endfunction

   // next schedule word from the sliding window (newest word in win[31:0]) and the stall decision
   always_comb begin
      nk_in    = bus.key_len == 2'd0 ? 4'd4 : bus.key_len == 2'd1 ? 4'd6 : 4'd8;
      legal    = bus.key_len != 2'd3 && 32 * int'(nk_in) <= MAX_KEY_BITS;
      nk       = kl == 2'd0 ? 4'd4 : kl == 2'd1 ? 4'd6 : 4'd8;
      nr       = nk + 4'd6;
      prev     = win[31:0];
      old      = kl == 2'd0 ? win[127:96] : kl == 2'd1 ? win[191:160] : win[255:224];
      sub_in   = mc == 3'd0 ? {prev[23:0], prev[31:24]} : prev;
      t        = mc == 3'd0 ? sub_word(sub_in) ^ {rcon, 24'h0} :
                 (nk == 4'd8 && mc == 3'd4) ? sub_word(sub_in) : prev;
      w        = old ^ t;
      hs       = bus.rk_valid & bus.rk_ready;
      out_free = !bus.rk_valid || bus.rk_ready;
      gen      = state == GEN && !(cc == 3'd4 && !out_free);
   end

   // control FSM, window shift, collector and registered round-key output
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         kl           <= 2'd0;
         win          <= '0;
         for (int k = 0; k < 4; k++) col[k] <= '0;
         cc           <= 3'd0;
         gi           <= 6'd0;
         mc           <= 3'd0;
         rcon         <= 8'h01;
         bus.busy     <= 1'b0;
         bus.err      <= 1'b0;
         bus.rk_valid <= 1'b0;
         bus.rk_data  <= '0;
         bus.rk_index <= 4'd0;
         bus.rk_last  <= 1'b0;
      end else begin
         bus.err <= state == IDLE && bus.start && !legal;
         if (state == IDLE) begin
            if (bus.start && legal) begin
               state        <= GEN;
               kl           <= bus.key_len;
               win          <= bus.key_len == 2'd0 ? {128'h0, bus.key_in[255:128]} :
                               bus.key_len == 2'd1 ? {64'h0, bus.key_in[255:64]} : bus.key_in;
               col[0]       <= bus.key_in[127:96];
               col[1]       <= bus.key_in[95:64];
               col[2]       <= bus.key_in[63:32];
               col[3]       <= bus.key_in[31:0];
               cc           <= 3'(nk_in - 4'd4);
               gi           <= 6'(nk_in);
               mc           <= 3'd0;
               rcon         <= 8'h01;
               bus.busy     <= 1'b1;
               bus.rk_valid <= 1'b1;
               bus.rk_data  <= bus.key_in[255:128];
               bus.rk_index <= 4'd0;
               bus.rk_last  <= 1'b0;
            end
         end else begin
            if (cc == 3'd4 && out_free) begin
               bus.rk_data  <= {col[0], col[1], col[2], col[3]};
               bus.rk_valid <= 1'b1;
               bus.rk_index <= bus.rk_index + 4'd1;
               bus.rk_last  <= bus.rk_index + 4'd1 == nr;
               if (gen) col[0] <= w;
               cc <= gen ? 3'd1 : 3'd0;
            end else if (gen && cc == 3'd3 && out_free) begin
               bus.rk_data  <= {col[0], col[1], col[2], w};
               bus.rk_valid <= 1'b1;
               bus.rk_index <= bus.rk_index + 4'd1;
               bus.rk_last  <= bus.rk_index + 4'd1 == nr;
               cc           <= 3'd0;
            end else begin
               if (hs) bus.rk_valid <= 1'b0;
               if (gen) begin
                  col[cc[1:0]] <= w;
                  cc           <= cc + 3'd1;
               end
            end
            if (gen) begin
               win <= {win[223:0], w};
               gi  <= gi + 6'd1;
               mc  <= mc == 3'(nk - 4'd1) ? 3'd0 : mc + 3'd1;
               if (mc == 3'd0) rcon <= xtime(rcon);
               if (gi == {nr, 2'b11}) state <= DRAIN;
            end
            if (state == DRAIN && hs && bus.rk_last) begin
               state        <= IDLE;
               bus.busy     <= 1'b0;
               bus.rk_valid <= 1'b0;
               bus.rk_last  <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_aes_key_expand.sv
// tb_aes_key_expand: checks the round-key stream against a FIPS-197 style key schedule model
module tb_aes_key_expand;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   aes_key_expand_if bus ();
   aes_key_expand_if bus2 ();
   aes_key_expand #(.MAX_KEY_BITS(256)) dut (.clk(clk), .rst(rst), .bus(bus));
   aes_key_expand #(.MAX_KEY_BITS(128)) dut_small (.clk(clk), .rst(rst), .bus(bus2));

   localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
   localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

   int n_tests = 0;
   int n_fail = 0;
   int cyc = 0;
   int t0 = 0;
   int got = 0;
   int nr_m = 0;
   bit active = 0;
   bit chk_en = 0;
   bit fresh = 0;
   bit timed = 0;
   bit rnd = 0;
   logic [7:0]   sbox_t [256];
   logic [7:0]   rcon_t [10];
   logic [127:0] exp_rk [15];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      logic [15:0] d;
      d = {x, x} << n;
      return d[15:8];
   endfunction

   // multiplicative-group walk: p runs over powers of 3, q over powers of 3^-1
   task automatic build_sbox();
      logic [7:0] p, q, x;
      p = 8'h01;
      q = 8'h01;
      do begin
         p = p ^ (p << 1) ^ ((p & 8'h80) != 0 ? 8'h1b : 8'h00);
         q = q ^ (q << 1);
         q = q ^ (q << 2);
         q = q ^ (q << 4);
         if ((q & 8'h80) != 0) q = q ^ 8'h09;
         x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
         sbox_t[p] = x ^ 8'h63;
      end while (p != 8'h01);
      sbox_t[0] = 8'h63;
      rcon_t = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
   endtask

   function automatic logic [31:0] sw(input logic [31:0] x);
      return {sbox_t[x[31:24]], sbox_t[x[23:16]], sbox_t[x[15:8]], sbox_t[x[7:0]]};
   endfunction

   task automatic build_model(input logic [255:0] key, input int nk);
      logic [31:0] w [60];
      logic [31:0] tmp;
      for (int i = 0; i < nk; i++) w[i] = key[255 - 32 * i -: 32];
      for (int i = nk; i < 4 * (nk + 7); i++) begin
         tmp = w[i - 1];
         if (i % nk == 0) tmp = sw({tmp[23:0], tmp[31:24]}) ^ {rcon_t[i / nk - 1], 24'h0};
         else if (nk > 6 && i % nk == 4) tmp = sw(tmp);
         w[i] = w[i - nk] ^ tmp;
      end
      for (int r = 0; r <= nk + 6; r++) exp_rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      bus.rk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // per-cycle compare of the key stream against the model; stalls must hold the same key
   always @(negedge clk) begin
      if (chk_en) begin
         if (active) begin
            chk("busy", 128'(bus.busy), 128'(1));
            chk("err_while_busy", 128'(bus.err), 128'(0));
            if (bus.rk_valid) begin
               if (got > nr_m) chk("extra_key", 128'(got), 128'(nr_m));
               else begin
                  chk("rk_data", bus.rk_data, exp_rk[got]);
                  chk("rk_index", 128'(bus.rk_index), 128'(got));
                  chk("rk_last", 128'(bus.rk_last), 128'(got == nr_m));
                  if (fresh && timed) chk("rk_time", 128'(cyc - t0), 128'(4 * got));
               end
               fresh = 0;
               if (bus.rk_ready) begin
                  got++;
                  fresh = 1;
                  if (got == nr_m + 1) active = 0;
               end
            end
         end else begin
            chk("idle_busy", 128'(bus.busy), 128'(0));
            chk("idle_valid", 128'(bus.rk_valid), 128'(0));
         end
      end
   end

   task automatic start_exp(input logic [255:0] key, input logic [1:0] kl, input bit timed_i);
      build_model(key, 4 + 2 * int'(kl));
      @(posedge clk);
      #2;
      bus.key_in = key;
      bus.key_len = kl;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      t0 = cyc;
      bus.start = 1'b0;
      got = 0;
      fresh = 1;
      nr_m = 10 + 2 * int'(kl);
      timed = timed_i;
      active = 1;
   endtask

   task automatic wait_done();
      for (int c = 0; c < 800 && active; c++) @(posedge clk);
      if (active) begin
         n_tests++;
         n_fail++;
         $display("FAIL timeout: got %0d of %0d keys", got, nr_m + 1);
         active = 0;
      end
      repeat (2) @(posedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_busy"}, 128'(bus.busy), 128'(0));
      chk({tag, "_err"}, 128'(bus.err), 128'(0));
      chk({tag, "_valid"}, 128'(bus.rk_valid), 128'(0));
      chk({tag, "_last"}, 128'(bus.rk_last), 128'(0));
      chk({tag, "_index"}, 128'(bus.rk_index), 128'(0));
      chk({tag, "_data"}, bus.rk_data, 128'(0));
   endtask

   initial begin
      bus.start = 1'b0;
      bus.key_len = 2'd0;
      bus.key_in = '0;
      bus.rk_ready = 1'b1;
      bus2.start = 1'b0;
      bus2.key_len = 2'd0;
      bus2.key_in = K128;
      bus2.rk_ready = 1'b1;
      build_sbox();
      chk("sbox_00", 128'(sbox_t[8'h00]), 128'h63);
      chk("sbox_01", 128'(sbox_t[8'h01]), 128'h7c);
      chk("sbox_53", 128'(sbox_t[8'h53]), 128'hed);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      chk("reset_small_valid", 128'(bus2.rk_valid), 128'(0));
      @(posedge clk);
      #1 rst = 1'b0;
      chk_en = 1;

      start_exp(K128, 2'd0, 1);
      chk("model128_rk1", exp_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
      chk("model128_rk10", exp_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      wait_done();
      chk("aes128_count", 128'(got), 128'(11));

      start_exp(K192, 2'd1, 0);
      chk("model192_rk12", exp_rk[12], 128'he98ba06f448c773c8ecc720401002202);
      wait_done();
      chk("aes192_count", 128'(got), 128'(13));

      start_exp(K256, 2'd2, 0);
      chk("model256_rk1", exp_rk[1], 128'h1f352c073b6108d72d9810a30914dff4);
      chk("model256_rk14", exp_rk[14], 128'hfe4890d1e6188d0b046df344706c631e);
      wait_done();
      chk("aes256_count", 128'(got), 128'(15));

      rnd = 1;
      start_exp(K256, 2'd2, 0);
      repeat (3) @(posedge clk);
      #2;
      bus.key_in = ~K256;
      bus.key_len = 2'd3;
      bus.start = 1'b1;
      @(posedge clk);
      #2 bus.start = 1'b0;
      wait_done();
      rnd = 0;
      chk("aes256_rnd_count", 128'(got), 128'(15));

      @(posedge clk);
      #2;
      bus.key_len = 2'd3;
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      @(negedge clk);
      chk("illegal_err", 128'(bus.err), 128'(1));
      chk("illegal_busy", 128'(bus.busy), 128'(0));
      chk("illegal_valid", 128'(bus.rk_valid), 128'(0));
      @(negedge clk);
      chk("illegal_err_one_cycle", 128'(bus.err), 128'(0));

      @(posedge clk);
      #2;
      bus2.key_len = 2'd2;
      bus2.start = 1'b1;
      @(posedge clk);
      #1 bus2.start = 1'b0;
      @(negedge clk);
      chk("small256_err", 128'(bus2.err), 128'(1));
      chk("small256_busy", 128'(bus2.busy), 128'(0));
      chk("small256_valid", 128'(bus2.rk_valid), 128'(0));
      @(negedge clk);
      chk("small256_err_one_cycle", 128'(bus2.err), 128'(0));
      @(posedge clk);
      #2;
      bus2.key_len = 2'd0;
      bus2.start = 1'b1;
      @(posedge clk);
      #1 bus2.start = 1'b0;
      @(negedge clk);
      chk("small128_busy", 128'(bus2.busy), 128'(1));
      chk("small128_rk0", bus2.rk_data, 128'h2b7e151628aed2a6abf7158809cf4f3c);
      chk("small128_err", 128'(bus2.err), 128'(0));

      @(posedge clk);
      #2;
      rst = 1'b1;
      bus.key_len = 2'd0;
      bus.key_in = K128;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.start = 1'b0;
      @(negedge clk);
      chk("rst_start_busy", 128'(bus.busy), 128'(0));
      chk("rst_start_valid", 128'(bus.rk_valid), 128'(0));

      start_exp(K128, 2'd0, 1);
      repeat (20) @(posedge clk);
      chk("keys_before_rst", 128'(got), 128'(5));
      #1;
      rst = 1'b1;
      chk_en = 0;
      active = 0;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("midrst");
      chk_en = 1;
      repeat (5) @(posedge clk);
      start_exp(K128, 2'd0, 1);
      wait_done();
      chk("after_rst_count", 128'(got), 128'(11));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
